data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter WIDTH, default 32: address and data width.
REQ-002 SHALL have parameter LINES, default 16: number of direct-mapped lines; each line holds 4 words.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port addr, input, WIDTH: byte address from the memory stage.
REQ-006 SHALL have port write_data, input, WIDTH: store data, already byte-lane aligned.
REQ-007 SHALL have port byte_en, input, 4: store byte enables.
REQ-008 SHALL have port mem_read, input, 1: load request.
REQ-009 SHALL have port mem_write, input, 1: store request.
REQ-010 SHALL have port read_data, output, WIDTH: raw load word; the memory stage performs sign/zero extension.
REQ-011 SHALL have port stall, output, 1: pipeline hold request.
REQ-012 SHALL have port bus_req, output, 1: backing-memory request valid.
REQ-013 SHALL have port bus_we, output, 1: backing-memory write.
REQ-014 SHALL have port bus_addr, output, WIDTH: word-aligned backing-memory address.
REQ-015 SHALL have port bus_wdata, output, WIDTH: backing-memory write data.
REQ-016 SHALL have port bus_be, output, 4: backing-memory byte enables.
REQ-017 SHALL have port bus_ready, input, 1: backing memory accepts or completes the current beat.
REQ-018 SHALL have port bus_rdata, input, WIDTH: read beat data, valid when bus_ready=1.

Function
REQ-019 SHALL decompose addr with LINES=16 as: [1:0] byte offset (ignored), [3:2] word, [7:4] index, [31:8] tag.
REQ-020 SHALL use a write-through, no-write-allocate policy, with per-line valid bits and tags.
REQ-021 SHALL implement FSM states IDLE, REFILL and WRITE.
REQ-022 IDLE, mem_read=1, mem_write=0, valid and tag match: read_data = cached word, combinationally; stall=0; no bus activity.
REQ-023 IDLE, mem_read=1, miss: stall=1; next state REFILL; refill word counter cleared to 0.
REQ-024 REFILL: bus_req=1, bus_we=0, bus_be=4'b1111, bus_addr={tag,index,cnt,2'b00}.
REQ-025 REFILL: on each bus_ready=1, store bus_rdata into word cnt of the line and increment cnt; cnt wraps 3->0.
REQ-026 REFILL: on the beat where cnt=3 and bus_ready=1, write the tag, set valid and go to IDLE.
REQ-027 REFILL: stall=1 throughout; the retried load then hits in IDLE, giving a miss penalty of 1+N cycles for N total beat cycles.
REQ-028 IDLE, mem_write=1: stall=1; next state WRITE; latch addr, write_data and byte_en.
REQ-029 WRITE: bus_req=1, bus_we=1, bus_addr={latched addr[31:2],2'b00}, bus_wdata and bus_be from the latched values.
REQ-030 WRITE: stall = ~bus_ready; on bus_ready=1, if the latched address hits, update only the enabled bytes of the cached word, then go to IDLE.
REQ-031 mem_read and mem_write both 1: treat as a write.
REQ-032 IDLE with neither request asserted: stall=0 and bus_req=0.
REQ-033 bus_ready SHALL be ignored whenever bus_req=0.
REQ-034 read_data SHALL be 0 whenever mem_read=0 or stall=1.
REQ-035 Bus outputs SHALL be held stable while bus_req=1 and bus_ready=0.

Reset
REQ-036 rst=1 SHALL, at the clock edge: set state to IDLE, clear all valid bits and cnt, and drive bus_req=0 and stall=0 (in IDLE with no request).
REQ-037 rst=1 during REFILL SHALL abort the refill, leaving the line invalid; rst=1 during WRITE SHALL abandon the bus write.
REQ-038 Tag and data arrays need no reset.

Verification
REQ-039 After reset, load addr 0x100 with beats 0xA0,0xA1,0xA2,0xA3, each ready after 1 cycle -> stall for the whole refill; bus_addr 0x100,0x104,0x108,0x10C; then read_data=0xA0 with stall=0.
REQ-040 Load 0x108 immediately after REQ-039 -> hit: read_data=0xA2, stall=0, bus_req=0.
REQ-041 Store 0x104, write_data 0x000000FF, byte_en 4'b0001, bus_ready delayed 3 cycles -> bus_we=1 with stable outputs; stall drops on the ready cycle; a later load of 0x104 returns 0x000000FF.
REQ-042 Store to uncached 0x200 -> bus write issued; a subsequent load of 0x200 misses and refills (no allocate on write).
REQ-043 Assert rst after the second refill beat of a miss on 0x300 -> IDLE, bus_req=0; reloading 0x300 refills again from beat 0.
REQ-044 Load 0x1100 (same index as 0x100, different tag) after REQ-039 -> miss and refill replaces the line; a load of 0x100 then misses.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Loads hit combinationally; misses refill the whole line from the backing bus.
module data_cache #(
  parameter int WIDTH = 32,
  parameter int LINES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic [3:0]       byte_en,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic [WIDTH-1:0] read_data,
  output logic             stall,
  output logic             bus_req,
  output logic             bus_we,
  output logic [WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0] bus_wdata,
  output logic [3:0]       bus_be,
  input  logic             bus_ready,
  input  logic [WIDTH-1:0] bus_rdata
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = WIDTH - IDX_W - 4;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        cnt_reg;
  logic [LINES-1:0]  valid_reg;
  logic [WIDTH-3:0]  word_addr_reg;
  logic [WIDTH-1:0]  wdata_reg;
  logic [3:0]        be_reg;

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [WIDTH-1:0]  data_mem [LINES*4];

  logic [TAG_W-1:0]  in_tag, lat_tag;
  logic [IDX_W-1:0]  in_idx, lat_idx;
  logic [1:0]        in_word, lat_word;
  logic              hit, lat_hit;
  logic [WIDTH-1:0]  cached_word, lat_data, merged;
  logic              start_write, start_refill, beat, last_beat, write_done;
  logic              unused_offset;

  assign in_tag   = addr[WIDTH-1:IDX_W+4];
  assign in_idx   = addr[IDX_W+3:4];
  assign in_word  = addr[3:2];
  assign lat_tag  = word_addr_reg[WIDTH-3:IDX_W+2];
  assign lat_idx  = word_addr_reg[IDX_W+1:2];
  assign lat_word = word_addr_reg[1:0];
  assign unused_offset = ^addr[1:0];

  assign hit         = valid_reg[in_idx] && (tag_mem[in_idx] == in_tag);
  assign lat_hit     = valid_reg[lat_idx] && (tag_mem[lat_idx] == lat_tag);
  assign cached_word = data_mem[{in_idx, in_word}];
  assign lat_data    = data_mem[{lat_idx, lat_word}];

  // Store hits merge the enabled lanes into the cached word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged[gi*8 +: 8] = be_reg[gi] ? wdata_reg[gi*8 +: 8] : lat_data[gi*8 +: 8];
    end
    if (WIDTH > 32) begin : g_upper
      assign merged[WIDTH-1:32] = lat_data[WIDTH-1:32];
    end
  endgenerate

  assign start_write  = (state_reg == IDLE) && mem_write;
  assign start_refill = (state_reg == IDLE) && mem_read && !mem_write && !hit;
  assign beat         = (state_reg == REFILL) && bus_ready;
  assign last_beat    = beat && (cnt_reg == 2'd3);
  assign write_done   = (state_reg == WRITE) && bus_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      valid_reg <= '0;
    end else begin
      state_reg <= state_next;
      // The line is invalidated up front so an aborted refill never leaves a mixed line valid.
      if (start_refill) begin
        cnt_reg           <= 2'd0;
        valid_reg[in_idx] <= 1'b0;
      end
      if (beat) begin
        cnt_reg <= cnt_reg + 2'd1;
        if (last_beat) valid_reg[lat_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_write || start_refill) word_addr_reg <= addr[WIDTH-1:2];
    if (start_write) begin
      wdata_reg <= write_data;
      be_reg    <= byte_en;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (beat)                  data_mem[{lat_idx, cnt_reg}]  <= bus_rdata;
      if (last_beat)             tag_mem[lat_idx]              <= lat_tag;
      if (write_done && lat_hit) data_mem[{lat_idx, lat_word}] <= merged;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (mem_write)         state_next = WRITE;
        else if (start_refill) state_next = REFILL;
      end
      REFILL:  if (last_beat) state_next = IDLE;
      WRITE:   if (bus_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    read_data = '0;
    stall     = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_be    = 4'b0000;
    case (state_reg)
      IDLE: begin
        stall = mem_write || start_refill;
        if (mem_read && !mem_write && hit) read_data = cached_word;
      end
      REFILL: begin
        stall    = 1'b1;
        bus_req  = 1'b1;
        bus_be   = 4'b1111;
        bus_addr = {word_addr_reg[WIDTH-3:2], cnt_reg, 2'b00};
      end
      WRITE: begin
        stall     = !bus_ready;
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = {word_addr_reg, 2'b00};
        bus_wdata = wdata_reg;
        bus_be    = be_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: backing-memory model with programmable latency and a
// scoreboard of expected bus beats compared against the beats the bus monitor sees.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0, write_data = '0;
  logic [3:0]  byte_en = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] read_data;
  logic        stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  data_cache #(.WIDTH(32), .LINES(16)) dut (
    .clk(clk), .rst(rst), .addr(addr), .write_data(write_data), .byte_en(byte_en),
    .mem_read(mem_read), .mem_write(mem_write), .read_data(read_data), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       obs_q[$];
  logic [31:0] mem_m [logic [31:0]];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          bus_delay = 0;
  int          wait_cnt = 0;
  int          unstable_cnt = 0;
  bit          in_txn = 0;
  logic [68:0] held;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem_m.exists(w)) return mem_m[w];
    return w ^ 32'h5A5A_0000;
  endfunction

  function automatic void push_beat(input logic we, input logic [31:0] a,
                                    input logic [31:0] d, input logic [3:0] be);
    beat_t b;
    b.we = we; b.addr = a; b.wdata = d; b.be = be;
    exp_q.push_back(b);
  endfunction

  function automatic void push_refill(input logic [31:0] a);
    for (int i = 0; i < 4; i++) push_beat(1'b0, {a[31:4], 4'h0} + 32'(i * 4), 32'h0, 4'hF);
  endfunction

  function automatic int refill_stalls(input int d);
    return 1 + 4 * (d + 1);
  endfunction

  // Backing memory: ready after bus_delay wait cycles per beat.
  always @(posedge clk) begin
    #1;
    if (bus_req) begin
      if (wait_cnt == bus_delay) begin
        bus_ready = 1'b1;
        bus_rdata = mem_rd(bus_addr);
        wait_cnt  = 0;
      end else begin
        bus_ready = 1'b0;
        bus_rdata = '0;
        wait_cnt++;
      end
    end else begin
      bus_ready = 1'b0;
      bus_rdata = '0;
      wait_cnt  = 0;
    end
  end

  // Bus monitor: records completed beats, applies writes, tracks output stability.
  always @(negedge clk) begin
    beat_t       b;
    logic [31:0] w;
    if (bus_req) begin
      if (!in_txn) begin
        in_txn = 1;
        held   = {bus_we, bus_addr, bus_wdata, bus_be};
      end else if ({bus_we, bus_addr, bus_wdata, bus_be} !== held) begin
        unstable_cnt++;
      end
      if (bus_ready) begin
        b.we = bus_we; b.addr = bus_addr; b.wdata = bus_wdata; b.be = bus_be;
        obs_q.push_back(b);
        if (bus_we) begin
          w = mem_rd(bus_addr);
          for (int i = 0; i < 4; i++) if (bus_be[i]) w[i*8 +: 8] = bus_wdata[i*8 +: 8];
          mem_m[bus_addr] = w;
        end
        in_txn = 0;
      end
    end else begin
      in_txn = 0;
    end
  end

  task automatic access(input bit rd_req, input bit wr_req, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd, output int stalls, output logic breq,
                        output bit rd_leak);
    bit done;
    done = 0; stalls = 0; rd = '0; breq = 1'b0; rd_leak = 0;
    @(negedge clk);
    mem_read = rd_req; mem_write = wr_req; addr = a; write_data = wd; byte_en = be;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (!stall) begin
        rd = read_data; breq = bus_req; done = 1;
      end else begin
        if (read_data !== 32'h0) rd_leak = 1;
        stalls++;
        @(negedge clk);
      end
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0; mem_write = 1'b0;
    $display("[TB] %s addr=%h wdata=%h be=%h -> read_data=%h stalls=%0d",
             wr_req ? "store" : "load ", a, wd, be, rd, stalls);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus_req !== 1'b0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got bus_req=%b stall=%b, expected 0 0", bus_req, stall);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (read_data !== 32'h0 || stall !== 1'b0 || bus_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_quiet: got read_data=%h stall=%b bus_req=%b, expected 0 0 0",
               read_data, stall, bus_req);
    end
    mem_read = 1'b1; addr = 32'h100;
    #1;
    tests_run++;
    if (stall !== 1'b1 || read_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL cold_miss: got stall=%b read_data=%h, expected 1 0", stall, read_data);
    end
    mem_read = 1'b0;
  endtask

  task automatic test_refill();
    logic [31:0] rd;
    int          st;
    logic        br;
    bit          leak;
    beat_t       e, o;
    mem_m[32'h100] = 32'hA0; mem_m[32'h104] = 32'hA1;
    mem_m[32'h108] = 32'hA2; mem_m[32'h10C] = 32'hA3;
    bus_delay = 1;
    push_refill(32'h100);
    access(1, 0, 32'h100, 32'h0, 4'h0, rd, st, br, leak);
    tests_run++;
    if (rd !== 32'hA0 || st != refill_stalls(1) || leak) begin
      tests_failed++;
      $display("FAIL refill_load: got data=%h stalls=%0d leak=%0b, expected %h %0d 0",
               rd, st, leak, 32'hA0, refill_stalls(1));
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      tests_run++;
      if (o.we !== e.we || o.addr !== e.addr || o.be !== e.be) begin
        tests_failed++;
        $display("FAIL refill_beat: got we=%b addr=%h be=%h, expected we=%b addr=%h be=%h",
                 o.we, o.addr, o.be, e.we, e.addr, e.be);
      end
    end
  endtask

  task automatic test_hit();
    logic [31:0] rd;
    int          st;
    logic        br;
    bit          leak;
    access(1, 0, 32'h108, 32'h0, 4'h0, rd, st, br, leak);
    tests_run++;
    if (rd !== 32'hA2 || st != 0 || br !== 1'b0 || obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL hit_108: got data=%h stalls=%0d bus_req=%b beats=%0d, expected A2 0 0 0",
               rd, st, br, obs_q.size());
    end
    access(1, 0, 32'h10C, 32'h0, 4'h0, rd, st, br, leak);
    tests_run++;
    if (rd !== 32'hA3 || st != 0) begin
      tests_failed++;
      $display("FAIL hit_10c: got data=%h stalls=%0d, expected A3 0", rd, st);
    end
  endtask

  task automatic test_store();
    logic [31:0] rd;
    int          st;
    logic        br;
    bit          leak;
    beat_t       e, o;
    bus_delay = 3;
    unstable_cnt = 0;
    push_beat(1'b1, 32'h104, 32'h0000_00FF, 4'b0001);
    access(0, 1, 32'h104, 32'h0000_00FF, 4'b0001, rd, st, br, leak);
    tests_run++;
    if (st != 4 || rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL store_stall: got stalls=%0d data=%h, expected 4 0", st, rd);
    end
    push_beat(1'b1, 32'h108, 32'h00FF_0000, 4'b0100);
    access(0, 1, 32'h10A, 32'h00FF_0000, 4'b0100, rd, st, br, leak);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      tests_run++;
      if (o.we !== e.we || o.addr !== e.addr || o.be !== e.be || o.wdata !== e.wdata) begin
        tests_failed++;
        $display("FAIL store_beat: got we=%b addr=%h be=%h wd=%h, expected we=%b addr=%h be=%h wd=%h",
                 o.we, o.addr, o.be, o.wdata, e.we, e.addr, e.be, e.wdata);
      end
    end
    tests_run++;
    if (unstable_cnt != 0) begin
      tests_failed++;
      $display("FAIL bus_stable: got %0d changes while waiting, expected 0", unstable_cnt);
    end
    access(1, 0, 32'h104, 32'h0, 4'h0, rd, st, br, leak);
    tests_run++;
    if (rd !== 32'h0000_00FF || st != 0) begin
      tests_failed++;
      $display("FAIL store_hit_104: got data=%h stalls=%0d, expected 000000ff 0", rd, st);
    end
    access(1, 0, 32'h108, 32'h0, 4'h0, rd, st, br, leak);
    tests_run++;
    if (rd !== 32'h00FF_00A2 || st != 0) begin
      tests_failed++;
      $display("FAIL store_merge_108: got data=%h stalls=%0d, expected 00ff00a2 0", rd, st);
    end
  endtask

  task automatic test_no_allocate();
    logic [31:0] rd;
    int          st;
    logic        br;
    bit          leak;
    beat_t       e, o;
    bus_delay = 0;
    push_beat(1'b1, 32'h200, 32'h1234_5678, 4'hF);
    access(0, 1, 32'h200, 32'h1234_5678, 4'hF, rd, st, br, leak);
    tests_run++;
    if (st != 1) begin
      tests_failed++;
      $display("FAIL store_200_stall: got %0d, expected 1", st);
    end
    push_refill(32'h200);
    access(1, 0, 32'h200, 32'h0, 4'h0, rd, st, br, leak);
    tests_run++;
    if (rd !== 32'h1234_5678 || st != refill_stalls(0)) begin
      tests_failed++;
      $display("FAIL no_allocate: got data=%h stalls=%0d, expected 12345678 %0d",
               rd, st, refill_stalls(0));
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      tests_run++;
      if (o.we !== e.we || o.addr !== e.addr || o.be !== e.be || (e.we && o.wdata !== e.wdata)) begin
        tests_failed++;
        $display("FAIL no_alloc_beat: got we=%b addr=%h be=%h wd=%h, expected we=%b addr=%h be=%h wd=%h",
                 o.we, o.addr, o.be, o.wdata, e.we, e.addr, e.be, e.wdata);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    int          st;
    logic        br;
    bit          leak;
    beat_t       e, o;
    int          n;
    bus_delay = 1;
    access(1, 0, 32'h140, 32'h0, 4'h0, rd, st, br, leak);
    exp_q.delete(); obs_q.delete();
    push_beat(1'b0, 32'h300, 32'h0, 4'hF);
    push_beat(1'b0, 32'h304, 32'h0, 4'hF);
    @(negedge clk);
    mem_read = 1'b1; addr = 32'h300;
    n = 0;
    while (obs_q.size() < 2 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    rst = 1'b1; mem_read = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (n >= 50 || bus_req !== 1'b0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_idle: got bus_req=%b stall=%b wait=%0d, expected 0 0 <50",
               bus_req, stall, n);
    end
    @(negedge clk);
    rst = 1'b0;
    push_refill(32'h300);
    access(1, 0, 32'h300, 32'h0, 4'h0, rd, st, br, leak);
    tests_run++;
    if (rd !== mem_rd(32'h300) || st != refill_stalls(1)) begin
      tests_failed++;
      $display("FAIL reload_300: got data=%h stalls=%0d, expected %h %0d",
               rd, st, mem_rd(32'h300), refill_stalls(1));
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      tests_run++;
      if (o.we !== e.we || o.addr !== e.addr || o.be !== e.be) begin
        tests_failed++;
        $display("FAIL abort_beat: got we=%b addr=%h be=%h, expected we=%b addr=%h be=%h",
                 o.we, o.addr, o.be, e.we, e.addr, e.be);
      end
    end
    access(1, 0, 32'h140, 32'h0, 4'h0, rd, st, br, leak);
    tests_run++;
    if (st != refill_stalls(1) || rd !== mem_rd(32'h140)) begin
      tests_failed++;
      $display("FAIL valid_cleared_140: got stalls=%0d data=%h, expected %0d %h",
               st, rd, refill_stalls(1), mem_rd(32'h140));
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_conflict();
    logic [31:0] rd;
    int          st;
    logic        br;
    bit          leak;
    beat_t       e, o;
    bus_delay = 0;
    access(1, 0, 32'h100, 32'h0, 4'h0, rd, st, br, leak);
    obs_q.delete();
    push_refill(32'h1100);
    access(1, 0, 32'h1100, 32'h0, 4'h0, rd, st, br, leak);
    tests_run++;
    if (rd !== mem_rd(32'h1100) || st != refill_stalls(0)) begin
      tests_failed++;
      $display("FAIL conflict_1100: got data=%h stalls=%0d, expected %h %0d",
               rd, st, mem_rd(32'h1100), refill_stalls(0));
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      tests_run++;
      if (o.we !== e.we || o.addr !== e.addr || o.be !== e.be) begin
        tests_failed++;
        $display("FAIL conflict_beat: got we=%b addr=%h be=%h, expected we=%b addr=%h be=%h",
                 o.we, o.addr, o.be, e.we, e.addr, e.be);
      end
    end
    access(1, 0, 32'h100, 32'h0, 4'h0, rd, st, br, leak);
    tests_run++;
    if (rd !== 32'hA0 || st != refill_stalls(0)) begin
      tests_failed++;
      $display("FAIL evicted_100: got data=%h stalls=%0d, expected a0 %0d", rd, st, refill_stalls(0));
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int          st;
    logic        br;
    bit          leak;
    beat_t       e, o;
    bus_delay = 0;
    push_beat(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    access(1, 1, 32'h100, 32'hDEAD_BEEF, 4'hF, rd, st, br, leak);
    tests_run++;
    if (st != 1 || rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL both_as_write: got stalls=%0d data=%h, expected 1 0", st, rd);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = '0;
      if (obs_q.size() != 0) o = obs_q.pop_front();
      tests_run++;
      if (o.we !== e.we || o.addr !== e.addr || o.be !== e.be || o.wdata !== e.wdata) begin
        tests_failed++;
        $display("FAIL both_beat: got we=%b addr=%h be=%h wd=%h, expected we=%b addr=%h be=%h wd=%h",
                 o.we, o.addr, o.be, o.wdata, e.we, e.addr, e.be, e.wdata);
      end
    end
    access(1, 0, 32'h100, 32'h0, 4'h0, rd, st, br, leak);
    tests_run++;
    if (rd !== 32'hDEAD_BEEF || st != 0 || br !== 1'b0) begin
      tests_failed++;
      $display("FAIL hit_after_both: got data=%h stalls=%0d bus_req=%b, expected deadbeef 0 0",
               rd, st, br);
    end
    access(1, 0, 32'h104, 32'h0, 4'h0, rd, st, br, leak);
    tests_run++;
    if (rd !== 32'h0000_00FF || st != 0) begin
      tests_failed++;
      $display("FAIL hit_104_refilled: got data=%h stalls=%0d, expected 000000ff 0", rd, st);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_refill();
    test_hit();
    test_store();
    test_no_allocate();
    test_reset_abort();
    test_conflict();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
